// File: rtl/obf_lut_seq_pkg.sv
// Shared constants, state type and helpers for the programmable substitution LUT.
package obf_lut_seq_pkg;

  localparam int unsigned IguWidth    = 7;
  localparam int unsigned AddrWidth   = 7;
  localparam int unsigned OutWidth    = 16;
  localparam int unsigned LenWidth    = 3;
  localparam int unsigned NumBanks    = 2;

  // Entry used by a disabled pointer.
  localparam int unsigned DefaultBase = 0;
  localparam int unsigned DefaultLen  = 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Pointer word layout, LSB-aligned: {en, len, base}.
  function automatic int unsigned ptr_width(input int unsigned aw, input int unsigned lw);
    return 1 + lw + aw;
  endfunction

  function automatic int unsigned ptr_len_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned ptr_en_bit(input int unsigned aw, input int unsigned lw);
    return aw + lw;
  endfunction

endpackage

// File: rtl/obf_lut_ptab.sv
// Per-bank pointer table: one write port, async clear to disabled, combinational read.
module obf_lut_ptab
  import obf_lut_seq_pkg::*;
#(
  parameter int unsigned IGU_WIDTH = IguWidth,
  parameter int unsigned BANKS     = NumBanks,
  parameter int unsigned BANK_W    = 1,
  parameter int unsigned PTR_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [BANK_W-1:0] wbank_i,
  input  logic [IGU_WIDTH-1:0] widx_i,
  input  logic [PTR_W-1:0]  wdata_i,
  input  logic [BANK_W-1:0] rbank_i,
  input  logic [IGU_WIDTH-1:0] ridx_i,
  output logic [PTR_W-1:0]  rdata_o
);

  localparam int unsigned Depth = 2 ** IGU_WIDTH;

  logic [PTR_W-1:0] ptr_q [BANKS][Depth];

  // Table storage; reset clears every entry so all indices fall back to the default entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < int'(BANKS); b++) begin
        for (int i = 0; i < int'(Depth); i++) begin
          ptr_q[b][i] <= '0;
        end
      end
    end else if (we_i) begin
      ptr_q[wbank_i][widx_i] <= wdata_i;
    end
  end

  assign rdata_o = ptr_q[rbank_i][ridx_i];

endmodule

// File: rtl/obf_lut_seq.sv
// Programmable multi-bank substitution sequencer: pointer lookup on accept, then one
// {sub, imm} pair per cycle read live from the entry RAM.
module obf_lut_seq
  import obf_lut_seq_pkg::*;
#(
  parameter int unsigned IGU_WIDTH  = IguWidth,
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned OUT_WIDTH  = OutWidth,
  parameter int unsigned LEN_WIDTH  = LenWidth,
  parameter int unsigned BANKS      = NumBanks,
  localparam int unsigned BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int unsigned CFG_AW    = max_u(ADDR_WIDTH, IGU_WIDTH),
  localparam int unsigned PTR_W     = ptr_width(ADDR_WIDTH, LEN_WIDTH),
  localparam int unsigned CFG_DW    = max_u(OUT_WIDTH, PTR_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [BANK_W-1:0]     cfg_bank,
  input  logic [CFG_AW-1:0]     cfg_addr,
  input  logic [CFG_DW-1:0]     cfg_wdata,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IGU_WIDTH-1:0]  req_index,
  input  logic [BANK_W-1:0]     req_bank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_sub,
  output logic [OUT_WIDTH-1:0]  out_imm,
  output logic [LEN_WIDTH-1:0]  out_ppc,
  output logic                  out_last
);

  localparam int unsigned RamDepth = 2 ** ADDR_WIDTH;
  localparam int unsigned LenLsb   = ptr_len_lsb(ADDR_WIDTH);
  localparam int unsigned EnBit    = ptr_en_bit(ADDR_WIDTH, LEN_WIDTH);

  logic [PTR_W-1:0]      ptr_rd;
  logic [ADDR_WIDTH-1:0] acc_base;
  logic [LEN_WIDTH-1:0]  acc_len;

  state_e                state_q;
  logic [BANK_W-1:0]     bank_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  ppc_q;
  logic                  last_q;
  logic                  valid_q;
  logic                  ready_q;

  logic [OUT_WIDTH-1:0]  mem_q [BANKS][RamDepth];
  logic [ADDR_WIDTH-1:0] sub_addr;
  logic [ADDR_WIDTH-1:0] imm_addr;

  obf_lut_ptab #(
    .IGU_WIDTH (IGU_WIDTH),
    .BANKS     (BANKS),
    .BANK_W    (BANK_W),
    .PTR_W     (PTR_W)
  ) u_ptab (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (cfg_we & cfg_sel),
    .wbank_i (cfg_bank),
    .widx_i  (cfg_addr[IGU_WIDTH-1:0]),
    .wdata_i (cfg_wdata[PTR_W-1:0]),
    .rbank_i (req_bank),
    .ridx_i  (req_index),
    .rdata_o (ptr_rd)
  );

  // Resolve the looked-up pointer into the base/len actually latched on accept.
  always_comb begin
    acc_base = ADDR_WIDTH'(DefaultBase);
    acc_len  = LEN_WIDTH'(DefaultLen);
    if (ptr_rd[EnBit]) begin
      acc_base = ptr_rd[ADDR_WIDTH-1:0];
      // An enabled pointer with len 0 still emits one pair.
      acc_len  = (ptr_rd[LenLsb +: LEN_WIDTH] == '0) ? LEN_WIDTH'(1)
                                                     : ptr_rd[LenLsb +: LEN_WIDTH];
    end
  end

  // Entry RAM write port; intentionally unreset.
  always_ff @(posedge clk) begin
    if (cfg_we && !cfg_sel) begin
      mem_q[cfg_bank][cfg_addr[ADDR_WIDTH-1:0]] <= cfg_wdata[OUT_WIDTH-1:0];
    end
  end

  // Sequencer FSM with registered handshake and position outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bank_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      ppc_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q <= StRun;
            bank_q  <= req_bank;
            base_q  <= acc_base;
            len_q   <= acc_len;
            ppc_q   <= '0;
            last_q  <= (acc_len == LEN_WIDTH'(1));
            valid_q <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        StRun: begin
          if (out_ready) begin
            if (last_q) begin
              state_q <= StIdle;
              ppc_q   <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              ppc_q  <= ppc_q + LEN_WIDTH'(1);
              // Next position is final when ppc+1 == len-1.
              last_q <= ((ppc_q + LEN_WIDTH'(2)) == len_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Address arithmetic wraps at the RAM depth.
  assign sub_addr  = base_q + ADDR_WIDTH'(ppc_q);
  assign imm_addr  = sub_addr + ADDR_WIDTH'(1);

  assign out_sub   = mem_q[bank_q][sub_addr];
  assign out_imm   = mem_q[bank_q][imm_addr];
  assign out_ppc   = ppc_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_obf_lut_seq.sv
// Scoreboard bench for obf_lut_seq: driver pushes hand-computed pairs, monitor pops on handshake.
module tb_obf_lut_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [0:0]  cfg_bank = '0;
  logic [6:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_index = '0;
  logic [0:0]  req_bank = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sub;
  logic [15:0] out_imm;
  logic [2:0]  out_ppc;
  logic        out_last;

  typedef struct packed {
    logic [15:0] sub;
    logic [15:0] imm;
    logic [2:0]  ppc;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   errors = 0;
  int   checks = 0;

  obf_lut_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_bank  (cfg_bank),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_index (req_index),
    .req_bank  (req_bank),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sub   (out_sub),
    .out_imm   (out_imm),
    .out_ppc   (out_ppc),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  // Monitor: every output handshake must match the oldest expected pair.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got sub=%h imm=%h ppc=%0d last=%b, want no output",
                 out_sub, out_imm, out_ppc, out_last);
      end else begin
        e_m = exp_q.pop_front();
        if ({out_sub, out_imm, out_ppc, out_last} !== e_m) begin
          errors++;
          $display("FAIL out_pair: got sub=%h imm=%h ppc=%0d last=%b, want sub=%h imm=%h ppc=%0d last=%b",
                   out_sub, out_imm, out_ppc, out_last, e_m.sub, e_m.imm, e_m.ppc, e_m.last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic sel, input logic b, input logic [6:0] a, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_bank  = b;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] i, input logic [2:0] p,
                      input logic l);
    exp_t e;
    e.sub  = s;
    e.imm  = i;
    e.ppc  = p;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Issue one request; checks readiness beforehand and the N+1 output latency.
  task automatic req(input logic [6:0] idx, input logic b);
    check("req_ready_before", 64'(req_ready), 64'd1);
    req_index = idx;
    req_bank  = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("first_valid", 64'({out_valid, req_ready, out_ppc}), 64'({1'b1, 1'b0, 3'd0}));
  endtask

  // Count edges until req_ready returns; bounded.
  task automatic wait_idle(input string name, input int exp_edges);
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(exp_edges));
  endtask

  initial begin
    tick();
    check("reset_outputs", 64'({req_ready, out_valid, out_last, out_ppc}),
          64'({1'b1, 1'b0, 1'b0, 3'd0}));
    tick();
    rst_n = 1'b1;
    tick();

    // Default entry after reset.
    cfg_wr(1'b0, 1'b0, 7'd0, 16'h0001);
    cfg_wr(1'b0, 1'b0, 7'd1, 16'h53BC);
    req(7'd27, 1'b0);
    push(16'h0001, 16'h53BC, 3'd0, 1'b1);
    wait_idle("default_len", 1);

    // Three-pair sequence: ptr {1,3,14}.
    cfg_wr(1'b1, 1'b0, 7'd29, 16'h058E);
    cfg_wr(1'b0, 1'b0, 7'd14, 16'hA00E);
    cfg_wr(1'b0, 1'b0, 7'd15, 16'hA00F);
    cfg_wr(1'b0, 1'b0, 7'd16, 16'hA010);
    cfg_wr(1'b0, 1'b0, 7'd17, 16'hA011);
    req(7'd29, 1'b0);
    push(16'hA00E, 16'hA00F, 3'd0, 1'b0);
    push(16'hA00F, 16'hA010, 3'd1, 1'b0);
    push(16'hA010, 16'hA011, 3'd2, 1'b1);
    wait_idle("three_pair_len", 3);

    // Backpressure at ppc=1 for three cycles.
    req(7'd29, 1'b0);
    push(16'hA00E, 16'hA00F, 3'd0, 1'b0);
    push(16'hA00F, 16'hA010, 3'd1, 1'b0);
    push(16'hA010, 16'hA011, 3'd2, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", 64'({out_valid, out_last, out_ppc, out_sub, out_imm}),
            64'({1'b1, 1'b0, 3'd1, 16'hA00F, 16'hA010}));
      tick();
    end
    out_ready = 1'b1;
    wait_idle("bp_drain", 2);

    // Pointer rewrite during RUN must not disturb the in-flight sequence.
    out_ready = 1'b0;
    req(7'd29, 1'b0);
    push(16'hA00E, 16'hA00F, 3'd0, 1'b0);
    push(16'hA00F, 16'hA010, 3'd1, 1'b0);
    push(16'hA010, 16'hA011, 3'd2, 1'b1);
    cfg_wr(1'b1, 1'b0, 7'd29, 16'h0480);
    out_ready = 1'b1;
    wait_idle("rewrite_inflight", 3);
    req(7'd29, 1'b0);
    push(16'h0001, 16'h53BC, 3'd0, 1'b1);
    wait_idle("rewrite_applied", 1);

    // Wrap-around: ptr {1,2,127}.
    cfg_wr(1'b1, 1'b0, 7'd5, 16'h057F);
    cfg_wr(1'b0, 1'b0, 7'd127, 16'h7F7F);
    req(7'd5, 1'b0);
    push(16'h7F7F, 16'h0001, 3'd0, 1'b0);
    push(16'h0001, 16'h53BC, 3'd1, 1'b1);
    wait_idle("wrap_len", 2);

    // Bank isolation: same index, bank 1 ptr {1,1,20}.
    cfg_wr(1'b1, 1'b1, 7'd29, 16'h0494);
    cfg_wr(1'b0, 1'b1, 7'd20, 16'hB014);
    cfg_wr(1'b0, 1'b1, 7'd21, 16'hB015);
    req(7'd29, 1'b1);
    push(16'hB014, 16'hB015, 3'd0, 1'b1);
    wait_idle("bank1_len", 1);

    // Enabled len 0 acts as len 1; live RAM write shows up the next cycle.
    cfg_wr(1'b1, 1'b0, 7'd30, 16'h0410);
    out_ready = 1'b0;
    req(7'd30, 1'b0);
    check("len0_first", 64'({out_sub, out_imm, out_last}), 64'({16'hA010, 16'hA011, 1'b1}));
    cfg_wr(1'b0, 1'b0, 7'd16, 16'hBEEF);
    check("ram_live", 64'(out_sub), 64'(16'hBEEF));
    push(16'hBEEF, 16'hA011, 3'd0, 1'b1);
    out_ready = 1'b1;
    wait_idle("len0_len", 1);

    // Reset mid-sequence abandons it and clears the pointer tables.
    out_ready = 1'b0;
    req(7'd5, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid", 64'({out_valid, req_ready, out_last, out_ppc}),
          64'({1'b0, 1'b1, 1'b0, 3'd0}));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    req(7'd29, 1'b0);
    push(16'h0001, 16'h53BC, 3'd0, 1'b1);
    wait_idle("post_reset_default", 1);

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
